// File: rtl/fifo_master_pkg.sv
// Shared constants for the slave-FIFO master scheduler: debug state
// encoding, socket addresses and the burst counter width.
package fifo_master_pkg;

  localparam int BCNT_W = 16;

  localparam logic [1:0] ADDR_WR = 2'b00;
  localparam logic [1:0] ADDR_RD = 2'b11;

  // One-hot debug encoding of the ten active states. IDLE has no bit of
  // its own and reads as all zeros, so STATE is 0 straight out of reset.
  localparam logic [9:0] ST_OH_IDLE    = 10'h000;
  localparam logic [9:0] ST_OH_WAIT    = 10'h001;
  localparam logic [9:0] ST_OH_SEL_W   = 10'h002;
  localparam logic [9:0] ST_OH_DRIVE   = 10'h004;
  localparam logic [9:0] ST_OH_WRITE   = 10'h008;
  localparam logic [9:0] ST_OH_PAUSE_W = 10'h010;
  localparam logic [9:0] ST_OH_SEL_R   = 10'h020;
  localparam logic [9:0] ST_OH_READ    = 10'h040;
  localparam logic [9:0] ST_OH_DRAIN_R = 10'h080;
  localparam logic [9:0] ST_OH_PAUSE_R = 10'h100;
  localparam logic [9:0] ST_OH_STOP    = 10'h200;

endpackage

// File: rtl/rd_valid_pipe.sv
// Delay line that turns the RD strobe into RD_VALID LAT cycles later.
module rd_valid_pipe #(
  parameter int unsigned LAT = 2
) (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_rd,
  output logic o_valid
);

  logic [LAT-1:0] r_sr;

  // Shift RD in at the bottom; synchronous clear drops reads in flight.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_sr <= '0;
    end else begin
      r_sr <= (r_sr << 1) | LAT'(i_rd);
    end
  end

  assign o_valid = r_sr[LAT-1];

endmodule

// File: rtl/fifo_master_scheduler.sv
// Round-robin scheduler for the slave-FIFO bus: one write thread on the
// DMA0 socket, one read thread on the DMA1 socket. Handles address setup,
// bus turnaround, burst limits, watermark pauses and read latency.
//
// Request qualification: a thread is eligible only while its request (it has
// data / room) and its socket Ready are both high in the same cycle. Once a
// grant is running, Ready is no longer consulted; the request and watermark
// are sampled every strobe cycle and the strobe of the sampling cycle counts.
module fifo_master_scheduler
  import fifo_master_pkg::*;
#(
  parameter int unsigned BURST_MAX = 1024,
  parameter int unsigned TURN_CYC  = 2,
  parameter int unsigned RD_LAT    = 2
) (
  input  logic              PCLK,
  input  logic              RESET_N,
  input  logic              ENABLE,
  input  logic              WR_REQ,
  input  logic              RD_REQ,
  input  logic              DMA0_Ready,
  input  logic              DMA0_Watermark,
  input  logic              DMA1_Ready,
  input  logic              DMA1_Watermark,
  output logic [1:0]        ADDR,
  output logic              OE,
  output logic              WR,
  output logic              RD,
  output logic              RD_VALID,
  output logic              LastWRData,
  output logic [BCNT_W-1:0] BURST_CNT,
  output logic [9:0]        STATE
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_WAIT    = 4'd1;
  localparam logic [3:0] S_SEL_W   = 4'd2;
  localparam logic [3:0] S_DRIVE   = 4'd3;
  localparam logic [3:0] S_WRITE   = 4'd4;
  localparam logic [3:0] S_PAUSE_W = 4'd5;
  localparam logic [3:0] S_SEL_R   = 4'd6;
  localparam logic [3:0] S_READ    = 4'd7;
  localparam logic [3:0] S_DRAIN_R = 4'd8;
  localparam logic [3:0] S_PAUSE_R = 4'd9;
  localparam logic [3:0] S_STOP    = 4'd10;

  localparam logic [BCNT_W-1:0] BMAX_C  = BCNT_W'(BURST_MAX);
  localparam logic [BCNT_W-1:0] BMAX_M1 = BCNT_W'(BURST_MAX - 1);
  localparam logic [2:0]        TURN_M1 = 3'(TURN_CYC - 1);
  localparam logic [2:0]        LAT_M1  = 3'(RD_LAT - 1);

  logic [3:0]        r_state;
  logic [2:0]        r_timer;
  logic [1:0]        r_addr;
  logic [BCNT_W-1:0] r_bcnt;
  logic              r_last_rd;
  logic              r_exit_wm;
  logic              r_exit_stop;

  logic [3:0] w_next;
  logic       w_wr_elig;
  logic       w_rd_elig;
  logic       w_grant_wr;
  logic       w_grant_rd;
  logic       w_limit;
  logic       w_strobe;
  logic       w_enter_sel_w;
  logic       w_enter_sel_r;
  logic       w_pipe_clr;

  assign w_wr_elig     = WR_REQ & DMA0_Ready;
  assign w_rd_elig     = RD_REQ & DMA1_Ready;
  // On a tie the thread that was not served last wins.
  assign w_grant_wr    = w_wr_elig & (~w_rd_elig | r_last_rd);
  assign w_grant_rd    = w_rd_elig & (~w_wr_elig | ~r_last_rd);
  assign w_limit       = (r_bcnt == BMAX_M1);
  assign w_strobe      = (r_state == S_WRITE) | (r_state == S_READ);
  assign w_enter_sel_w = (r_state == S_WAIT) & (w_next == S_SEL_W);
  assign w_enter_sel_r = (r_state == S_WAIT) & (w_next == S_SEL_R);
  assign w_pipe_clr    = ~RESET_N;

  // Next-state logic: stop beats watermark beats request drop / limit.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (ENABLE) w_next = S_WAIT;
      S_WAIT: begin
        if (!ENABLE)         w_next = S_STOP;
        else if (w_grant_wr) w_next = S_SEL_W;
        else if (w_grant_rd) w_next = S_SEL_R;
      end
      S_SEL_W:   if (r_timer == TURN_M1) w_next = S_DRIVE;
      S_DRIVE:   w_next = S_WRITE;
      S_WRITE: begin
        if (!ENABLE)                 w_next = S_STOP;
        else if (DMA0_Watermark)     w_next = S_PAUSE_W;
        else if (!WR_REQ || w_limit) w_next = S_WAIT;
      end
      S_PAUSE_W: begin
        if (!ENABLE)          w_next = S_STOP;
        else if (!DMA0_Ready) w_next = S_WAIT;
      end
      S_SEL_R:   if (r_timer == TURN_M1) w_next = S_READ;
      S_READ: begin
        if (!ENABLE || DMA1_Watermark || !RD_REQ || w_limit) w_next = S_DRAIN_R;
      end
      S_DRAIN_R: begin
        if (r_timer == LAT_M1) begin
          if (!ENABLE || r_exit_stop) w_next = S_STOP;
          else if (r_exit_wm)         w_next = S_PAUSE_R;
          else                        w_next = S_WAIT;
        end
      end
      S_PAUSE_R: begin
        if (!ENABLE)          w_next = S_STOP;
        else if (!DMA1_Ready) w_next = S_WAIT;
      end
      S_STOP:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // State register plus a dwell timer that restarts on every state change.
  always_ff @(posedge PCLK) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      r_timer <= (w_next != r_state) ? 3'd0 : r_timer + 3'd1;
    end
  end

  // Socket address and last-served thread change only when a grant is made.
  always_ff @(posedge PCLK) begin
    if (!RESET_N) begin
      r_addr    <= ADDR_WR;
      r_last_rd <= 1'b1;
    end else if (w_enter_sel_w) begin
      r_addr    <= ADDR_WR;
      r_last_rd <= 1'b0;
    end else if (w_enter_sel_r) begin
      r_addr    <= ADDR_RD;
      r_last_rd <= 1'b1;
    end
  end

  // Strobe counter: cleared per grant and in IDLE, saturating at the limit.
  always_ff @(posedge PCLK) begin
    if (!RESET_N) begin
      r_bcnt <= '0;
    end else if (w_enter_sel_w || w_enter_sel_r || w_next == S_IDLE) begin
      r_bcnt <= '0;
    end else if (w_strobe && r_bcnt != BMAX_C) begin
      r_bcnt <= r_bcnt + BCNT_W'(1);
    end
  end

  // Remember why a read burst ended so DRAIN_R knows where to go next.
  always_ff @(posedge PCLK) begin
    if (!RESET_N) begin
      r_exit_wm   <= 1'b0;
      r_exit_stop <= 1'b0;
    end else if (r_state == S_READ && w_next == S_DRAIN_R) begin
      r_exit_stop <= ~ENABLE;
      r_exit_wm   <= DMA1_Watermark;
    end
  end

  // Debug view of the state register.
  always_comb begin
    STATE = ST_OH_IDLE;
    case (r_state)
      S_WAIT:    STATE = ST_OH_WAIT;
      S_SEL_W:   STATE = ST_OH_SEL_W;
      S_DRIVE:   STATE = ST_OH_DRIVE;
      S_WRITE:   STATE = ST_OH_WRITE;
      S_PAUSE_W: STATE = ST_OH_PAUSE_W;
      S_SEL_R:   STATE = ST_OH_SEL_R;
      S_READ:    STATE = ST_OH_READ;
      S_DRAIN_R: STATE = ST_OH_DRAIN_R;
      S_PAUSE_R: STATE = ST_OH_PAUSE_R;
      S_STOP:    STATE = ST_OH_STOP;
      default:   STATE = ST_OH_IDLE;
    endcase
  end

  assign ADDR       = r_addr;
  assign OE         = (r_state == S_DRIVE) | (r_state == S_WRITE);
  assign WR         = (r_state == S_WRITE);
  assign RD         = (r_state == S_READ);
  assign LastWRData = (r_state == S_STOP);
  assign BURST_CNT  = r_bcnt;

  rd_valid_pipe #(
    .LAT (RD_LAT)
  ) u_rd_valid_pipe (
    .i_clk   (PCLK),
    .i_clr   (w_pipe_clr),
    .i_rd    (RD),
    .o_valid (RD_VALID)
  );

endmodule

// File: tb/tb_fifo_master_scheduler.sv
// Bench for fifo_master_scheduler: directed scenarios followed by random
// grants, checked against transaction-level expectations.
module tb_fifo_master_scheduler;

  localparam int BMAX = 8;
  localparam int TURN = 2;
  localparam int LAT  = 2;

  localparam logic [9:0] ST_IDLE    = 10'h000;
  localparam logic [9:0] ST_WAIT    = 10'h001;
  localparam logic [9:0] ST_SEL_W   = 10'h002;
  localparam logic [9:0] ST_DRIVE   = 10'h004;
  localparam logic [9:0] ST_WRITE   = 10'h008;
  localparam logic [9:0] ST_PAUSE_W = 10'h010;
  localparam logic [9:0] ST_SEL_R   = 10'h020;
  localparam logic [9:0] ST_READ    = 10'h040;
  localparam logic [9:0] ST_DRAIN_R = 10'h080;
  localparam logic [9:0] ST_PAUSE_R = 10'h100;
  localparam logic [9:0] ST_STOP    = 10'h200;

  logic PCLK = 1'b0;
  logic RESET_N = 1'b0;
  logic ENABLE = 1'b0;
  logic WR_REQ = 1'b0;
  logic RD_REQ = 1'b0;
  logic DMA0_Ready = 1'b0;
  logic DMA0_Watermark = 1'b0;
  logic DMA1_Ready = 1'b0;
  logic DMA1_Watermark = 1'b0;
  logic [1:0]  ADDR;
  logic        OE, WR, RD, RD_VALID, LastWRData;
  logic [15:0] BURST_CNT;
  logic [9:0]  STATE;

  int vectors = 0;
  int miscompares = 0;
  logic [0:0] exp_q[$];     // RD history, newest at the back
  bit last_rd_model = 1'b1; // thread served last; read after reset

  fifo_master_scheduler #(
    .BURST_MAX (BMAX),
    .TURN_CYC  (TURN),
    .RD_LAT    (LAT)
  ) dut (
    .PCLK           (PCLK),
    .RESET_N        (RESET_N),
    .ENABLE         (ENABLE),
    .WR_REQ         (WR_REQ),
    .RD_REQ         (RD_REQ),
    .DMA0_Ready     (DMA0_Ready),
    .DMA0_Watermark (DMA0_Watermark),
    .DMA1_Ready     (DMA1_Ready),
    .DMA1_Watermark (DMA1_Watermark),
    .ADDR           (ADDR),
    .OE             (OE),
    .WR             (WR),
    .RD             (RD),
    .RD_VALID       (RD_VALID),
    .LastWRData     (LastWRData),
    .BURST_CNT      (BURST_CNT),
    .STATE          (STATE)
  );

  // Clock
  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // One clock; RD_VALID is checked every cycle as RD delayed by LAT.
  task automatic tick();
    logic rd_before, rst_before, exp_valid;
    rd_before  = RD;
    rst_before = RESET_N;
    @(posedge PCLK);
    #1;
    if (!rst_before) begin
      exp_q.delete();
    end else begin
      exp_q.push_back(rd_before);
      if (exp_q.size() > LAT) void'(exp_q.pop_front());
    end
    exp_valid = (exp_q.size() == LAT) ? exp_q[0] : 1'b0;
    chk("rd_valid", 16'(RD_VALID), 16'(exp_valid));
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_state"}, 16'(STATE), 16'(ST_IDLE));
    chk({tag, "_addr"},  16'(ADDR), 16'h0);
    chk({tag, "_wr"},    16'(WR), 16'h0);
    chk({tag, "_rd"},    16'(RD), 16'h0);
    chk({tag, "_oe"},    16'(OE), 16'h0);
    chk({tag, "_last"},  16'(LastWRData), 16'h0);
    chk({tag, "_bcnt"},  BURST_CNT, 16'h0);
  endtask

  // From WAIT4DMA through address setup (and DRIVE for writes).
  task automatic start_grant(input bit is_rd);
    chk("grant_wait", 16'(STATE), 16'(ST_WAIT));
    last_rd_model = is_rd;
    tick();
    for (int t = 0; t < TURN; t++) begin
      chk("sel_state", 16'(STATE), 16'(is_rd ? ST_SEL_R : ST_SEL_W));
      chk("sel_addr", 16'(ADDR), is_rd ? 16'h3 : 16'h0);
      chk("sel_bcnt", BURST_CNT, 16'h0);
      tick();
    end
    if (!is_rd) begin
      chk("drive_state", 16'(STATE), 16'(ST_DRIVE));
      chk("drive_oe", 16'(OE), 16'h1);
      chk("drive_wr", 16'(WR), 16'h0);
      tick();
    end
  endtask

  // Strobe run and its exit. Event positions are 1-based strobe indices, 0 = never.
  task automatic strobe_phase(input bit is_rd, input int wm_at, input int drop_at,
                              input int stop_at, input int hold);
    int  n_exp, n_obs;
    bit  to_stop, to_pause;
    n_exp = BMAX;
    if (wm_at > 0 && wm_at < n_exp)     n_exp = wm_at;
    if (drop_at > 0 && drop_at < n_exp) n_exp = drop_at;
    if (stop_at > 0 && stop_at < n_exp) n_exp = stop_at;
    to_stop  = (stop_at == n_exp);
    to_pause = !to_stop && (wm_at == n_exp);
    n_obs = 0;
    while (((is_rd ? RD : WR) === 1'b1) && n_obs < BMAX + 4) begin
      n_obs++;
      chk("strobe_bcnt", BURST_CNT, 16'(n_obs - 1));
      chk("strobe_addr", 16'(ADDR), is_rd ? 16'h3 : 16'h0);
      chk("strobe_oe", 16'(OE), is_rd ? 16'h0 : 16'h1);
      if (is_rd) begin
        DMA1_Watermark = (n_obs == wm_at);
        RD_REQ = (n_obs != drop_at);
      end else begin
        DMA0_Watermark = (n_obs == wm_at);
        WR_REQ = (n_obs != drop_at);
      end
      if (n_obs == stop_at) ENABLE = 1'b0;
      tick();
    end
    chk("strobe_count", 16'(n_obs), 16'(n_exp));
    DMA0_Watermark = 1'b0;
    DMA1_Watermark = 1'b0;
    if (is_rd) begin
      for (int d = 0; d < LAT; d++) begin
        chk("drain_state", 16'(STATE), 16'(ST_DRAIN_R));
        chk("drain_rd", 16'(RD), 16'h0);
        tick();
      end
    end
    if (to_stop) begin
      chk("stop_state", 16'(STATE), 16'(ST_STOP));
      chk("stop_last", 16'(LastWRData), 16'h1);
      tick();
      chk("stop_idle", 16'(STATE), 16'(ST_IDLE));
      chk("stop_last_off", 16'(LastWRData), 16'h0);
      chk("stop_bcnt", BURST_CNT, 16'h0);
      ENABLE = 1'b1;
      tick();
      chk("restart_wait", 16'(STATE), 16'(ST_WAIT));
    end else if (to_pause) begin
      chk("pause_bcnt", BURST_CNT, 16'(n_exp));
      if (is_rd) DMA1_Ready = 1'b1; else DMA0_Ready = 1'b1;
      for (int h = 0; h < hold; h++) begin
        chk("pause_hold", 16'(STATE), 16'(is_rd ? ST_PAUSE_R : ST_PAUSE_W));
        tick();
      end
      if (is_rd) DMA1_Ready = 1'b0; else DMA0_Ready = 1'b0;
      chk("pause_state", 16'(STATE), 16'(is_rd ? ST_PAUSE_R : ST_PAUSE_W));
      tick();
      chk("pause_exit", 16'(STATE), 16'(ST_WAIT));
    end else begin
      chk("end_state", 16'(STATE), 16'(ST_WAIT));
      chk("end_bcnt", BURST_CNT, 16'(n_exp));
    end
  endtask

  // Present eligibility in WAIT4DMA and run whichever grant round-robin picks.
  task automatic grant(input bit we, input bit re, input int wm_at, input int drop_at,
                       input int stop_at, input int hold);
    bit pick_rd;
    WR_REQ     = we | ($urandom_range(0, 1) == 1);
    DMA0_Ready = we | !WR_REQ;
    RD_REQ     = re | ($urandom_range(0, 1) == 1);
    DMA1_Ready = re | !RD_REQ;
    if (!we && !re) begin
      tick();
      chk("no_grant", 16'(STATE), 16'(ST_WAIT));
      return;
    end
    pick_rd = re && (!we || !last_rd_model);
    start_grant(pick_rd);
    strobe_phase(pick_rd, wm_at, drop_at, stop_at, hold);
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    tick();
    last_rd_model = 1'b1;
    chk_idle_outputs("reset");
    RESET_N = 1'b1;
    ENABLE  = 1'b1;
    tick();
    chk("post_reset_wait", 16'(STATE), 16'(ST_WAIT));
  endtask

  // Start a grant and pull reset on strobe number at.
  task automatic reset_mid(input bit is_rd, input int at);
    WR_REQ = !is_rd; DMA0_Ready = !is_rd;
    RD_REQ = is_rd;  DMA1_Ready = is_rd;
    start_grant(is_rd);
    for (int k = 1; k < at; k++) begin
      chk("pre_reset_strobe", 16'(is_rd ? RD : WR), 16'h1);
      tick();
    end
    chk("reset_strobe", 16'(BURST_CNT), 16'(at - 1));
    do_reset();
  endtask

  initial begin
    // Reset state
    RESET_N = 1'b0;
    tick();
    tick();
    chk_idle_outputs("init");
    RESET_N = 1'b1;
    tick();
    chk("idle_hold", 16'(STATE), 16'(ST_IDLE));
    ENABLE = 1'b1;
    tick();

    // Write only: two back-to-back full bursts
    grant(1'b1, 1'b0, 0, 0, 0, 0);
    grant(1'b1, 1'b0, 0, 0, 0, 0);

    // Tie from reset: write, read, write, read
    do_reset();
    for (int i = 0; i < 4; i++) grant(1'b1, 1'b1, 0, 0, 0, 0);

    // Watermark on 5th WR, pause held 10 cycles
    grant(1'b1, 1'b0, 5, 0, 0, 10);
    // Read watermark tied with request drop, then tied with the limit
    grant(1'b0, 1'b1, 4, 4, 0, 3);
    grant(1'b0, 1'b1, BMAX, 0, 0, 1);
    // Write stop beating a watermark
    grant(1'b1, 1'b0, 2, 0, 2, 0);
    // Stop on 3rd RD
    grant(1'b0, 1'b1, 0, 0, 3, 0);

    // Reset mid-write and mid-read, then restart
    reset_mid(1'b0, 4);
    grant(1'b1, 1'b0, 0, 0, 0, 0);
    reset_mid(1'b1, 3);
    grant(1'b1, 1'b1, 0, 0, 0, 0);

    // Random grants
    for (int it = 0; it < 40; it++) begin
      bit we, re;
      int wm, drop, stp, hold;
      we   = ($urandom_range(0, 3) != 0);
      re   = ($urandom_range(0, 3) != 0);
      wm   = $urandom_range(0, 12);
      drop = $urandom_range(0, 12);
      stp  = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 10) : 0;
      hold = $urandom_range(0, 4);
      grant(we, re, wm, drop, stp, hold);
    end

    // Stop straight from WAIT4DMA
    WR_REQ = 1'b0; RD_REQ = 1'b0;
    ENABLE = 1'b0;
    tick();
    chk("wait_stop", 16'(STATE), 16'(ST_STOP));
    chk("wait_stop_last", 16'(LastWRData), 16'h1);
    tick();
    chk("final_idle", 16'(STATE), 16'(ST_IDLE));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_master_scheduler.md
# fifo_master_scheduler

Sequences the CPLD slave-FIFO bus between a write thread (DMA0 socket) and a read thread (DMA1 socket). It replaces the static Select strap with a round-robin arbiter. It has per-grant burst limits, address setup and bus turnaround, and read-latency tracking. It sits between the data source/sink logic and the DQ/WR/RD/ADDR pins of the FIFO master top level.

## Interface
- BURST_MAX, 1024: maximum strobes per grant, range 2..65535
- TURN_CYC, 2: cycles ADDR is stable before the first strobe; also the bus turnaround gap; range 1..7
- RD_LAT, 2: cycles from RD to valid data on DQ; range 1..4
- PCLK  in  1  sole clock, rising edge
- RESET_N  in  1  synchronous, active-low reset
- ENABLE  in  1  run level, already synchronized to PCLK
- WR_REQ  in  1  write thread has data to send
- RD_REQ  in  1  read thread has room to receive
- DMA0_Ready, DMA0_Watermark  in  1 each  write socket flags
- DMA1_Ready, DMA1_Watermark  in  1 each  read socket flags
- ADDR  out  2  socket select: 2'b00 write, 2'b11 read
- OE  out  1  drive DQ
- WR  out  1  write strobe; the source advances its data on every WR cycle
- RD  out  1  read strobe
- RD_VALID  out  1  DQ holds read data this cycle
- LastWRData  out  1  packet-end flag
- BURST_CNT  out  16  strobes issued in the current grant
- STATE  out  10  one-hot state, for the User debug port

## Operation
- States:
  - IDLE
  - WAIT4DMA (arbitrate)
  - SEL_W
  - DRIVE
  - WRITE
  - PAUSE_W
  - SEL_R
  - READ
  - DRAIN_R
  - PAUSE_R
  - STOP
- IDLE: go to WAIT4DMA when ENABLE=1. BURST_CNT is cleared.
- WAIT4DMA:
  - If ENABLE=0, go to STOP.
  - Otherwise arbitrate. Write is eligible when WR_REQ&DMA0_Ready; read is eligible when RD_REQ&DMA1_Ready.
  - If both are eligible, grant the thread not served last. The last-served register resets to "read", so the first tie goes to write.
  - A write grant goes to SEL_W; a read grant goes to SEL_R.
- SEL_W / SEL_R: drive ADDR for TURN_CYC cycles, then go to DRIVE or READ respectively.
- DRIVE: OE=1 for exactly one cycle, then WRITE.
- WRITE: WR=1 and OE=1. Exits, highest priority first:
  - ENABLE=0 → STOP
  - DMA0_Watermark → PAUSE_W
  - WR_REQ=0, or BURST_CNT==BURST_MAX-1 → WAIT4DMA
- PAUSE_W: wait for DMA0_Ready=0, or for ENABLE=0 (→ STOP); then go to WAIT4DMA.
- READ: RD=1. Exits use the same priority as WRITE, with DMA1_Watermark and RD_REQ. Every exit passes through DRAIN_R.
- DRAIN_R: hold for RD_LAT cycles, then:
  - → STOP if ENABLE=0
  - → PAUSE_R if the exit was a watermark exit
  - → WAIT4DMA otherwise
- PAUSE_R: the PAUSE_W rule applied to DMA1.
- STOP: LastWRData=1 for one cycle, then IDLE.
- ADDR holds its last value in every state that does not select a socket.
- BURST_CNT:
  - increments on each WR or RD cycle
  - clears on entry to SEL_W/SEL_R
  - saturates at BURST_MAX
- The one-hot encoding is decoded combinationally from the state register. No output depends combinationally on the inputs.

## Timing
- Reset: on the first PCLK edge with RESET_N=0, the FSM goes to IDLE. All outputs are 0 from that edge, including ADDR=00, BURST_CNT=0 and RD_VALID=0; the read pipeline is cleared. Reset mid-burst truncates the burst with no LastWRData pulse.
- Grant to first strobe: 1 cycle in WAIT4DMA, then TURN_CYC cycles in SEL, then (write only) 1 cycle in DRIVE.
- The strobe on the cycle a watermark or limit is sampled is the last strobe. A write burst is exactly its count of WRITE cycles.
- RD_VALID equals RD delayed by RD_LAT cycles. The last RD_VALID falls on the final DRAIN_R cycle.
- Back-to-back grants are separated by at least 1 + TURN_CYC idle cycles, which gives bus turnaround.
- Simultaneous events in one cycle:
  - ENABLE=0 with a watermark → STOP wins.
  - Watermark with a request drop → pause.
  - Limit with a watermark → pause.

## Structure
- Shared package fifo_master_pkg holds:
  - the one-hot state constants (10 states)
  - ADDR_WR = 2'b00 and ADDR_RD = 2'b11
  - the BURST_CNT width
- Sub-module rd_valid_pipe: an RD_LAT-deep shift register that produces RD_VALID, with synchronous clear.

## Test plan
- Write only: DMA0_Ready=1, WR_REQ=1, no watermark, BURST_MAX=8 → ADDR=00 for 2 cycles, 1 DRIVE cycle, 8 WR cycles; then 1+2 idle cycles and a new 8-WR grant.
- Tie: both threads eligible from reset → write grant first, then read, alternating. RD runs of 8 with RD_VALID trailing by 2 cycles.
- Watermark: DMA0_Watermark raised on the 5th WR → exactly 5 WR; stay in PAUSE_W until DMA0_Ready=0 (held 10 cycles), then WAIT4DMA.
- Stop: ENABLE=0 on the 3rd RD → 3 RD, 2 DRAIN_R cycles, LastWRData for 1 cycle, then IDLE.
- Reset mid-write: RESET_N=0 on the 4th WR → WR, OE and ADDR are 0 after that edge and STATE=IDLE. After release with ENABLE=1 the write grant restarts with BURST_CNT=0.
